// File: rtl/clk_en_scheduler.sv
// clk_en_scheduler
// Central clock-enable generator for the 100 MHz domain. NUM_CH independent
// programmable dividers each produce a one-cycle tick and a 50% square output
// of period 2N. Divisors are reprogrammed through a valid/ready port and a new
// divisor only takes effect at the target channel's period boundary (or while
// the channel is stopped, or on a sync restart), so no runt period is emitted.
//
// Build option: define CLK_EN_SCHED_CFG_CHECK_EN to reject zero divisors and
// out-of-range channels with a cfg_err pulse alongside cfg_done. Without it,
// cfg_err is tied low, a zero divisor is stored and behaves as one, and an
// out-of-range channel is dropped silently (cfg_done still pulses).
module clk_en_scheduler #(
  parameter int NUM_CH    = 3,
  parameter int CNT_W     = 20,
  parameter int CH_W      = 2,
  parameter int DIV0_INIT = 2,
  parameter int DIV1_INIT = 100000,
  parameter int DIVN_INIT = 1000
) (
  input  logic              clk_100MHz,
  input  logic              reset_n,
  input  logic              sync_rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_done,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    DONE = 2'd2
  } cfg_state_t;

  // Channel count widened by one bit so NUM_CH == 2^CH_W still compares correctly
  localparam logic [CH_W:0] NUM_CH_EXT = (CH_W + 1)'(NUM_CH);

  logic [CNT_W-1:0]  cnt     [NUM_CH];
  logic [CNT_W-1:0]  divisor [NUM_CH];
  logic [CNT_W-1:0]  term    [NUM_CH];
  logic [NUM_CH-1:0] at_term;

  cfg_state_t       state;
  cfg_state_t       state_next;
  logic [CH_W-1:0]  lat_ch;
  logic [CNT_W-1:0] lat_div;
  logic             accept;
  logic             reject;
  logic             apply;
  logic             ch_in_range;

`ifdef CLK_EN_SCHED_CFG_CHECK_EN
  logic             err_flag;
`endif

  function automatic logic [CNT_W-1:0] init_div(input int idx);
    if (idx == 0) begin
      return CNT_W'(DIV0_INIT);
    end else if (idx == 1) begin
      return CNT_W'(DIV1_INIT);
    end else begin
      return CNT_W'(DIVN_INIT);
    end
  endfunction

  // Terminal count per channel; a zero divisor is forced to one before the subtract so it never wraps
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      term[i]    = ((divisor[i] == '0) ? CNT_W'(1) : divisor[i]) - CNT_W'(1);
      at_term[i] = (cnt[i] == term[i]);
    end
  end

  // Decide whether the request on the port must be turned away without waiting
  always_comb begin
    ch_in_range = ({1'b0, cfg_ch} < NUM_CH_EXT);
`ifdef CLK_EN_SCHED_CFG_CHECK_EN
    reject      = !ch_in_range || (cfg_div == '0);
`else
    reject      = !ch_in_range;
`endif
  end

  // A pending divisor lands on the channel's boundary edge, while it is stopped, or on a sync restart
  always_comb begin
    apply = 1'b0;
    if (state == PEND) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if ((lat_ch == CH_W'(i)) && (at_term[i] || !ch_en[i] || sync_rst)) begin
          apply = 1'b1;
        end
      end
    end
  end

  // Config FSM next state and handshake outputs
  always_comb begin
    state_next = state;
    cfg_ready  = 1'b0;
    cfg_done   = 1'b0;
    cfg_err    = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          accept     = 1'b1;
          state_next = reject ? DONE : PEND;
        end
      end
      PEND: begin
        if (apply) begin
          state_next = DONE;
        end
      end
      DONE: begin
        cfg_done   = 1'b1;
`ifdef CLK_EN_SCHED_CFG_CHECK_EN
        cfg_err    = err_flag;
`endif
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Config FSM state register; reset discards any request in flight
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture the request at the handshake so the requester can move on while it waits
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      lat_ch  <= '0;
      lat_div <= '0;
    end else if (accept) begin
      lat_ch  <= cfg_ch;
      lat_div <= cfg_div;
    end
  end

`ifdef CLK_EN_SCHED_CFG_CHECK_EN
  // Remember whether the accepted request was rejected so DONE can flag it
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      err_flag <= 1'b0;
    end else if (accept) begin
      err_flag <= reject;
    end
  end
`endif

  // Divisor registers; only the latched channel changes, and only on its apply edge
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        divisor[i] <= init_div(i);
      end
    end else if (apply) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (lat_ch == CH_W'(i)) begin
          divisor[i] <= lat_div;
        end
      end
    end
  end

  // Per-channel divider: sync restart wins, a stopped channel parks at zero, otherwise count to terminal
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i] <= '0;
      end
      tick   <= '0;
      sq_out <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (sync_rst) begin
          cnt[i]    <= '0;
          tick[i]   <= 1'b0;
          sq_out[i] <= 1'b0;
        end else if (!ch_en[i]) begin
          cnt[i]    <= '0;
          tick[i]   <= 1'b0;
        end else if (at_term[i]) begin
          cnt[i]    <= '0;
          tick[i]   <= 1'b1;
          sq_out[i] <= ~sq_out[i];
        end else begin
          cnt[i]    <= cnt[i] + CNT_W'(1);
          tick[i]   <= 1'b0;
        end
      end
    end
  end

endmodule
